// File: rtl/sfm_tcdm_responder.sv
// Memory-side TCDM responder: word-addressed storage with req/gnt request acceptance and
// in-order r_valid/r_ready responses after a fixed latency, credit-limited by RESP_DEPTH.
module sfm_tcdm_responder #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int UW         = 1,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 2,
    parameter int RESP_DEPTH = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clear_i,
    input  logic                            stall_i,
    input  logic                            tcdm_req_i,
    output logic                            tcdm_gnt_o,
    input  logic [ADDR_WIDTH-1:0]           tcdm_add_i,
    input  logic                            tcdm_wen_i,
    input  logic [DATA_WIDTH/8-1:0]         tcdm_be_i,
    input  logic [DATA_WIDTH-1:0]           tcdm_data_i,
    input  logic [UW-1:0]                   tcdm_user_i,
    output logic                            tcdm_r_valid_o,
    input  logic                            tcdm_r_ready_i,
    output logic [DATA_WIDTH-1:0]           tcdm_r_data_o,
    output logic [UW-1:0]                   tcdm_r_user_o,
    output logic [$clog2(RESP_DEPTH+1)-1:0] outstanding_o
);

    localparam int BW  = DATA_WIDTH / 8;
    localparam int OFF = (BW > 1) ? $clog2(BW) : 0;
    localparam int IW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int OW  = $clog2(RESP_DEPTH + 1);
    localparam int PW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int NST = LATENCY - 1;

    // Handshakes: a request is accepted in any cycle where req and gnt are both high; a
    // response is consumed in any cycle where r_valid and r_ready are both high. Once
    // raised, r_valid holds with stable data/user until it is consumed (or clear/reset).

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [IW-1:0]         word_idx;
    logic                  accept;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [OW-1:0]         outstanding_q;
    logic                  unused_add;

    logic                  push_valid;
    logic [DATA_WIDTH-1:0] push_data;
    logic [UW-1:0]         push_user;

    logic [DATA_WIDTH-1:0] fifo_data [RESP_DEPTH];
    logic [UW-1:0]         fifo_user [RESP_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [OW-1:0]         fifo_cnt;
    logic                  pop;

    assign word_idx   = tcdm_add_i[OFF +: IW];
    assign unused_add = ^tcdm_add_i;

    // Credit check on outstanding guarantees the FIFO can absorb every accepted request.
    assign tcdm_gnt_o = ~rst_i & ~stall_i & ~clear_i & (outstanding_q < OW'(RESP_DEPTH));
    assign accept     = tcdm_req_i & tcdm_gnt_o;

    // Read data is sampled before this cycle's write lands; writes answer with zero.
    assign rsp_data   = tcdm_wen_i ? mem[word_idx] : '0;

    always_ff @(posedge clk_i) begin
        if (accept && !tcdm_wen_i) begin
            for (int b = 0; b < BW; b++) begin
                if (tcdm_be_i[b]) begin
                    mem[word_idx][b*8 +: 8] <= tcdm_data_i[b*8 +: 8];
                end
            end
        end
    end

    generate
        if (NST == 0) begin : g_no_delay
            assign push_valid = accept;
            assign push_data  = rsp_data;
            assign push_user  = tcdm_user_i;
        end else begin : g_delay
            logic [NST-1:0]        dl_valid;
            logic [DATA_WIDTH-1:0] dl_data [NST];
            logic [UW-1:0]         dl_user [NST];

            // Valid bits carry the flush; payload stages just follow along.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    dl_valid <= '0;
                end else if (clear_i) begin
                    dl_valid <= '0;
                end else begin
                    dl_valid[0] <= accept;
                    for (int i = 1; i < NST; i++) begin
                        dl_valid[i] <= dl_valid[i-1];
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                dl_data[0] <= rsp_data;
                dl_user[0] <= tcdm_user_i;
                for (int i = 1; i < NST; i++) begin
                    dl_data[i] <= dl_data[i-1];
                    dl_user[i] <= dl_user[i-1];
                end
            end

            assign push_valid = dl_valid[NST-1];
            assign push_data  = dl_data[NST-1];
            assign push_user  = dl_user[NST-1];
        end
    endgenerate

    assign tcdm_r_valid_o = (fifo_cnt != '0);
    assign pop            = tcdm_r_valid_o & tcdm_r_ready_i;
    assign tcdm_r_data_o  = tcdm_r_valid_o ? fifo_data[rd_ptr] : '0;
    assign tcdm_r_user_o  = tcdm_r_valid_o ? fifo_user[rd_ptr] : '0;

    always_ff @(posedge clk_i) begin
        if (push_valid && !clear_i) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_user[wr_ptr] <= push_user;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (clear_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_valid) begin
                wr_ptr <= (wr_ptr == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            fifo_cnt <= fifo_cnt + OW'(push_valid) - OW'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else if (clear_i) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_q + OW'(accept) - OW'(pop);
        end
    end

    assign outstanding_o = outstanding_q;

endmodule
